axi4_wr_tlp_decoder: RTL and testbench

//  Successor to the dummy AXI4 write-decoding stub: AXI4 write slave (AW+W) to TLP-like MemWr stream.

---
 rtl/axi4_wr_tlp_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_axi4_wr_tlp_decoder.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_wr_tlp_decoder.sv
// axi4_wr_tlp_decoder
// AXI4 write slave (AW + W channels) that re-emits each write burst as a
// stream of MemWr-style chunks. A chunk holds at most CHUNK_MAX_BEATS beats
// and never crosses a 4 KB address boundary. Each output beat carries the
// base address and DW length of the chunk it belongs to.
//
// Optional build feature, enabled by defining the macro DEC_WLAST_CHECK_EN:
//   - adds the wlast_err output, a one-cycle pulse registered with the beat;
//   - an early s_wlast ends the burst on that beat and forces out_eop;
//   - a missing s_wlast on the final beat only pulses wlast_err.
// In the default build s_wlast is ignored. The beat count comes from s_awlen.
module axi4_wr_tlp_decoder #(
  parameter int          ID_WIDTH        = 4,
  parameter int          ADDR_WIDTH      = 32,
  parameter int          DATA_WIDTH      = 256,
  parameter int          CHUNK_MAX_BEATS = 4,
  parameter logic [15:0] BDF             = 16'h0200
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_awid,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic [7:0]            s_awlen,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic                  s_wlast,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [9:0]            out_length,
  output logic [15:0]           out_bdf,
  output logic                  out_is_memwrite,
  output logic [DATA_WIDTH-1:0] out_wdata
`ifdef DEC_WLAST_CHECK_EN
  ,
  output logic                  wlast_err
`endif
);

  localparam int BYTES_PER_BEAT = DATA_WIDTH / 8;
  localparam int DW_PER_BEAT    = DATA_WIDTH / 32;
  localparam int OFF_W          = $clog2(BYTES_PER_BEAT);
  localparam logic [8:0] MAX_BEATS = 9'(CHUNK_MAX_BEATS);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;

  // Beats in the next chunk: limited by what remains of the burst, by the
  // chunk cap, and by the room left before the next 4 KB boundary. The
  // address is beat-aligned, so the room is an exact number of beats.
  function automatic logic [8:0] calc_chunk(input logic [11:0] a_lo,
                                            input logic [8:0]  rem);
    logic [12:0] room_bytes;
    logic [12:0] room_beats;
    logic [8:0]  n;
    room_bytes = 13'd4096 - {1'b0, a_lo};
    room_beats = room_bytes >> OFF_W;
    n = rem;
    if (n > MAX_BEATS) n = MAX_BEATS;
    if ({4'b0, n} > room_beats) n = room_beats[8:0];
    return n;
  endfunction

  // Chunk length in DW. The 10-bit field wraps, so 1024 DW encodes as 0.
  function automatic logic [9:0] chunk_len(input logic [8:0] n);
    logic [31:0] dw;
    dw = 32'(n) * 32'(DW_PER_BEAT);
    return dw[9:0];
  endfunction

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;          // base address of current chunk
  logic [8:0]            beats_rem_q, beats_rem_d; // beats left in burst, incl. current chunk
  logic [8:0]            chunk_beats_q, chunk_beats_d;
  logic [8:0]            beat_idx_q, beat_idx_d;

  logic                  out_valid_q, out_valid_d;
  logic                  out_sop_q, out_sop_d;
  logic                  out_eop_q, out_eop_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [9:0]            out_length_q, out_length_d;
  logic [DATA_WIDTH-1:0] out_wdata_q, out_wdata_d;
  logic                  wlast_err_q, wlast_err_d;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  last_in_chunk;
  logic                  final_beat;
  logic                  early_last;

  // s_awid and the sub-beat address bits carry no information for the
  // output stream. s_wlast is only consulted when the check is built in.
  logic                  unused_ok;
  assign unused_ok = ^{s_awid, s_wlast, s_awaddr[OFF_W-1:0]};

  assign s_awready       = (state_q == ST_IDLE);
  assign s_wready        = (state_q == ST_DATA) && (!out_valid_q || out_ready);
  assign aw_hs           = s_awvalid && s_awready;
  assign w_hs            = s_wvalid && s_wready;
  assign last_in_chunk   = (beat_idx_q == chunk_beats_q - 9'd1);
  assign final_beat      = last_in_chunk && (beats_rem_q == chunk_beats_q);

  assign out_valid       = out_valid_q;
  assign out_sop         = out_sop_q;
  assign out_eop         = out_eop_q;
  assign out_addr        = out_addr_q;
  assign out_length      = out_length_q;
  assign out_wdata       = out_wdata_q;
  assign out_bdf         = BDF;
  assign out_is_memwrite = 1'b1;
`ifdef DEC_WLAST_CHECK_EN
  assign wlast_err       = wlast_err_q;
`endif

  // Next-state logic: burst acceptance, chunk sequencing and output register load.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    beats_rem_d   = beats_rem_q;
    chunk_beats_d = chunk_beats_q;
    beat_idx_d    = beat_idx_q;
    out_valid_d   = out_valid_q;
    out_sop_d     = out_sop_q;
    out_eop_d     = out_eop_q;
    out_addr_d    = out_addr_q;
    out_length_d  = out_length_q;
    out_wdata_d   = out_wdata_q;
    wlast_err_d   = 1'b0;
    early_last    = 1'b0;

    // The held beat leaves on its handshake unless a new one replaces it below.
    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          addr_d        = {s_awaddr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          beats_rem_d   = {1'b0, s_awlen} + 9'd1;
          chunk_beats_d = calc_chunk(addr_d[11:0], beats_rem_d);
          beat_idx_d    = 9'd0;
          state_d       = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          out_valid_d  = 1'b1;
          out_wdata_d  = s_wdata;
          out_sop_d    = (beat_idx_q == 9'd0);
          out_eop_d    = last_in_chunk;
          out_addr_d   = addr_q;
          out_length_d = chunk_len(chunk_beats_q);
`ifdef DEC_WLAST_CHECK_EN
          early_last  = s_wlast && !final_beat;
          wlast_err_d = early_last || (final_beat && !s_wlast);
`endif
          if (early_last) begin
            // Burst cut short: close the chunk here, header length is left as issued.
            out_eop_d = 1'b1;
            state_d   = ST_IDLE;
          end else if (last_in_chunk) begin
            addr_d      = addr_q + (ADDR_WIDTH'(chunk_beats_q) << OFF_W);
            beats_rem_d = beats_rem_q - chunk_beats_q;
            beat_idx_d  = 9'd0;
            if (beats_rem_d == 9'd0) begin
              state_d = ST_IDLE;
            end else begin
              chunk_beats_d = calc_chunk(addr_d[11:0], beats_rem_d);
            end
          end else begin
            beat_idx_d = beat_idx_q + 9'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      beats_rem_q   <= '0;
      chunk_beats_q <= '0;
      beat_idx_q    <= '0;
      out_valid_q   <= 1'b0;
      out_sop_q     <= 1'b0;
      out_eop_q     <= 1'b0;
      out_addr_q    <= '0;
      out_length_q  <= '0;
      out_wdata_q   <= '0;
      wlast_err_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      beats_rem_q   <= beats_rem_d;
      chunk_beats_q <= chunk_beats_d;
      beat_idx_q    <= beat_idx_d;
      out_valid_q   <= out_valid_d;
      out_sop_q     <= out_sop_d;
      out_eop_q     <= out_eop_d;
      out_addr_q    <= out_addr_d;
      out_length_q  <= out_length_d;
      out_wdata_q   <= out_wdata_d;
      wlast_err_q   <= wlast_err_d;
    end
  end

endmodule

// File: tb/tb_axi4_wr_tlp_decoder.sv
// Testbench for axi4_wr_tlp_decoder: directed bursts, expected output beats
// queued as W beats are accepted and compared as the DUT emits them.
module tb_axi4_wr_tlp_decoder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   s_awid = '0;
  logic [31:0]  s_awaddr = '0;
  logic [7:0]   s_awlen = '0;
  logic         s_awvalid = 1'b0;
  logic         s_awready;
  logic [255:0] s_wdata = '0;
  logic         s_wlast = 1'b0;
  logic         s_wvalid = 1'b0;
  logic         s_wready;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_sop;
  logic         out_eop;
  logic [31:0]  out_addr;
  logic [9:0]   out_length;
  logic [15:0]  out_bdf;
  logic         out_is_memwrite;
  logic [255:0] out_wdata;
`ifdef DEC_WLAST_CHECK_EN
  logic         wlast_err;
`endif

  always #5 clk = ~clk;

  axi4_wr_tlp_decoder dut (
    .clk             (clk),
    .rst             (rst),
    .s_awid          (s_awid),
    .s_awaddr        (s_awaddr),
    .s_awlen         (s_awlen),
    .s_awvalid       (s_awvalid),
    .s_awready       (s_awready),
    .s_wdata         (s_wdata),
    .s_wlast         (s_wlast),
    .s_wvalid        (s_wvalid),
    .s_wready        (s_wready),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sop         (out_sop),
    .out_eop         (out_eop),
    .out_addr        (out_addr),
    .out_length      (out_length),
    .out_bdf         (out_bdf),
    .out_is_memwrite (out_is_memwrite),
    .out_wdata       (out_wdata)
`ifdef DEC_WLAST_CHECK_EN
    ,
    .wlast_err       (wlast_err)
`endif
  );

  typedef struct {
    logic [31:0]  addr;
    logic [9:0]   len;
    logic         sop;
    logic         eop;
    logic [255:0] data;
  } beat_t;

  beat_t plan[$];   // beats of the current burst not yet handed to the DUT
  beat_t sb[$];     // beats accepted by the DUT, awaiting output
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mkdata(input int i);
    logic [31:0] w;
    w = 32'hA500_0000 + 32'(i);
    return {8{w}};
  endfunction

  // Expected beats of a burst with 32-byte beats, chunks of at most 4 beats, split at 4 KB.
  task automatic plan_burst(input logic [31:0] addr, input int len, input int base);
    logic [31:0] a;
    int rem, n, room, i;
    beat_t b;
    a = addr & ~32'h1F;
    rem = len + 1;
    i = 0;
    while (rem > 0) begin
      room = (4096 - int'(a[11:0])) / 32;
      n = (rem < 4) ? rem : 4;
      if (room < n) n = room;
      for (int k = 0; k < n; k++) begin
        b.addr = a;
        b.len  = 10'(n * 8);
        b.sop  = (k == 0);
        b.eop  = (k == n - 1);
        b.data = mkdata(base + i);
        i++;
        plan.push_back(b);
      end
      a = a + 32'(n * 32);
      rem = rem - n;
    end
  endtask

  task automatic aw(input logic [31:0] addr, input logic [7:0] len);
    int t;
    s_awaddr = addr;
    s_awlen = len;
    s_awvalid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_awready && t < 50);
    check("aw_ready", s_awready, 1'b1);
    @(posedge clk);
    #1;
    s_awvalid = 1'b0;
  endtask

  task automatic wbeat(input logic last);
    beat_t b;
    int t;
    if (plan.size() == 0) begin
      check("plan_empty", 1'b0, 1'b1);
      return;
    end
    b = plan.pop_front();
    s_wdata = b.data;
    s_wlast = last;
    s_wvalid = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!s_wready && t < 50);
    check("w_ready", s_wready, 1'b1);
    @(posedge clk);
    sb.push_back(b);
    #1;
    s_wlast = 1'b0;
  endtask

  task automatic drain();
    int t;
    s_wvalid = 1'b0;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk);
      t++;
    end
    #1;
    check("drain", 256'(sb.size()), 256'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_awready"}, s_awready, 1'b1);
    check({tag, "_wready"}, s_wready, 1'b0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_sop"}, out_sop, 1'b0);
    check({tag, "_eop"}, out_eop, 1'b0);
    check({tag, "_addr"}, out_addr, 32'h0);
    check({tag, "_length"}, out_length, 10'h0);
    check({tag, "_wdata"}, out_wdata, 256'h0);
  endtask

  // Output monitor: every completed output handshake must match the oldest accepted beat.
  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_beat", out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("out_addr", out_addr, e.addr);
        check("out_length", out_length, e.len);
        check("out_sop", out_sop, e.sop);
        check("out_eop", out_eop, e.eop);
        check("out_wdata", out_wdata, e.data);
        check("out_bdf", out_bdf, 16'h0200);
        check("out_is_memwrite", out_is_memwrite, 1'b1);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [31:0]  snap_addr;
    logic [9:0]   snap_len;
    logic         snap_sop, snap_eop;
    logic [255:0] snap_data;

    // Reset values
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 0x1000, 4 beats, single chunk; W offered together with AW must wait
    plan_burst(32'h1000, 3, 0);
    s_awaddr = 32'h1000;
    s_awlen = 8'd3;
    s_awvalid = 1'b1;
    s_wdata = plan[0].data;
    s_wvalid = 1'b1;
    @(negedge clk);
    check("same_cycle_awready", s_awready, 1'b1);
    check("same_cycle_wready", s_wready, 1'b0);
    @(posedge clk);
    #1;
    s_awvalid = 1'b0;
    for (int i = 0; i < 4; i++) wbeat(i == 3);
    @(negedge clk);
    check("burst_end_awready", s_awready, 1'b1);
    check("burst_end_wready", s_wready, 1'b0);
    drain();

    // 0x2000, 10 beats -> 4/4/2, with a 5-cycle downstream stall mid-chunk
    plan_burst(32'h2000, 9, 100);
    aw(32'h2000, 8'd9);
    wbeat(1'b0);
    wbeat(1'b0);
    out_ready = 1'b0;
    s_wdata = plan[0].data;
    s_wvalid = 1'b1;
    @(negedge clk);
    snap_addr = out_addr;
    snap_len = out_length;
    snap_sop = out_sop;
    snap_eop = out_eop;
    snap_data = out_wdata;
    check("stall_snap_data", snap_data, mkdata(101));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_wready", s_wready, 1'b0);
      check("stall_valid", out_valid, 1'b1);
      check("stall_addr", out_addr, snap_addr);
      check("stall_length", out_length, snap_len);
      check("stall_sop", out_sop, snap_sop);
      check("stall_eop", out_eop, snap_eop);
      check("stall_wdata", out_wdata, snap_data);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 2; i < 10; i++) wbeat(i == 9);
    drain();

    // 0x0FC0, 4 beats -> split at the 4 KB boundary
    plan_burst(32'h0FC0, 3, 200);
    aw(32'h0FC0, 8'd3);
    for (int i = 0; i < 4; i++) wbeat(i == 3);
    drain();

    // Reset pulsed while beat 2 of an 8-beat burst is offered
    plan_burst(32'h0000, 7, 300);
    aw(32'h0000, 8'd7);
    wbeat(1'b0);
    wbeat(1'b0);
    s_wdata = plan[0].data;
    s_wvalid = 1'b1;
    #2;
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("midburst_reset");
    sb.delete();
    plan.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    s_wvalid = 1'b0;

    // Fresh burst after reset: 0x3000, 1 beat, length 8
    plan_burst(32'h3000, 0, 400);
    aw(32'h3000, 8'd0);
    wbeat(1'b1);
    drain();

`ifdef DEC_WLAST_CHECK_EN
    // Early s_wlast on beat 1 of a 4-beat burst
    plan_burst(32'h4000, 3, 500);
    aw(32'h4000, 8'd3);
    wbeat(1'b0);
    plan[0].eop = 1'b1;
    wbeat(1'b1);
    @(negedge clk);
    check("wlast_err_pulse", wlast_err, 1'b1);
    check("early_wlast_idle", s_awready, 1'b1);
    plan.delete();
    s_wvalid = 1'b0;
    @(negedge clk);
    check("wlast_err_clear", wlast_err, 1'b0);
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
